// File: rtl/digiota_trim_cal.sv
`default_nettype none
// ============================================================================
// Module  : digiota_trim_cal
// Brief   : Successive-approximation offset-trim calibrator for the digital OTA
// Rev     : 1.0 - initial release
// ============================================================================
module digiota_trim_cal #(
  parameter int TRIM_W        = 6,
  parameter int SETTLE_CYCLES = 16,
  parameter int VOTES         = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cmp_in,
  output logic [TRIM_W-1:0] trim,
  output logic [TRIM_W-1:0] cal_code,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam int SC_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int VC_W  = $clog2(VOTES + 1);

  localparam logic [2:0] c_s_idle   = 3'd0;
  localparam logic [2:0] c_s_set    = 3'd1;
  localparam logic [2:0] c_s_settle = 3'd2;
  localparam logic [2:0] c_s_sample = 3'd3;
  localparam logic [2:0] c_s_decide = 3'd4;
  localparam logic [2:0] c_s_done   = 3'd5;

  localparam logic [TRIM_W-1:0] c_mid         = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [TRIM_W-1:0] c_one         = TRIM_W'(1);
  localparam logic [IDX_W-1:0]  c_idx_msb     = IDX_W'(TRIM_W - 1);
  localparam logic [SC_W-1:0]   c_settle_last = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [VC_W-1:0]   c_vote_last   = VC_W'(VOTES - 1);
  localparam logic [VC_W-1:0]   c_vote_half   = VC_W'(VOTES / 2);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic              r_cmp_meta;
  logic              r_cmp_sync;
  logic [IDX_W-1:0]  r_idx;
  logic [TRIM_W-1:0] r_trial;
  logic [TRIM_W-1:0] r_trim;
  logic [TRIM_W-1:0] r_cal;
  logic [SC_W-1:0]   r_scnt;
  logic [VC_W-1:0]   r_vcnt;
  logic [VC_W-1:0]   r_ones;

  logic [TRIM_W-1:0] w_bit;
  logic              w_keep;
  logic [TRIM_W-1:0] w_decided;

  assign w_bit     = c_one << r_idx;
  assign w_keep    = (r_ones > c_vote_half);
  assign w_decided = w_keep ? r_trial : (r_trial & ~w_bit);

  // Comparator output is asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_meta <= 1'b0;
      r_cmp_sync <= 1'b0;
    end else begin
      r_cmp_meta <= cmp_in;
      r_cmp_sync <= r_cmp_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_s_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (abort && (r_state != c_s_idle)) begin
      w_next_state = c_s_idle;
    end else begin
      case (r_state)
        c_s_idle:   if (start && !abort) w_next_state = c_s_set;
        c_s_set:    w_next_state = c_s_settle;
        c_s_settle: if (r_scnt == c_settle_last) w_next_state = c_s_sample;
        c_s_sample: if (r_vcnt == c_vote_last) w_next_state = c_s_decide;
        c_s_decide: w_next_state = (r_idx == '0) ? c_s_done : c_s_set;
        c_s_done:   w_next_state = c_s_idle;
        default:    w_next_state = c_s_idle;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      c_s_set, c_s_settle, c_s_sample, c_s_decide: busy = 1'b1;
      c_s_done:                                    done = 1'b1;
      default:                                     ;
    endcase
  end

  // Abort leaves the stored result untouched and puts it back on the bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= c_idx_msb;
      r_trial <= '0;
      r_trim  <= c_mid;
      r_cal   <= c_mid;
      r_scnt  <= '0;
      r_vcnt  <= '0;
      r_ones  <= '0;
    end else if (abort && (r_state != c_s_idle)) begin
      r_trim <= r_cal;
    end else begin
      case (r_state)
        c_s_idle: begin
          r_trim <= r_cal;
          if (start && !abort) begin
            r_trial <= '0;
            r_idx   <= c_idx_msb;
          end
        end
        c_s_set: begin
          r_trial <= r_trial | w_bit;
          r_trim  <= r_trial | w_bit;
          r_scnt  <= '0;
          r_vcnt  <= '0;
          r_ones  <= '0;
        end
        c_s_settle: begin
          r_scnt <= r_scnt + SC_W'(1);
        end
        c_s_sample: begin
          r_vcnt <= r_vcnt + VC_W'(1);
          r_ones <= r_ones + VC_W'(r_cmp_sync);
        end
        c_s_decide: begin
          r_trial <= w_decided;
          r_trim  <= w_decided;
          if (r_idx == '0) begin
            r_cal <= w_decided;
          end else begin
            r_idx <= r_idx - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign trim     = r_trim;
  assign cal_code = r_cal;

endmodule
`default_nettype wire

// File: tb/tb_digiota_trim_cal.sv
`default_nettype none
// ============================================================================
// Module  : tb_digiota_trim_cal
// Brief   : Scoreboard bench for the SAR trim calibrator with a search model
// Rev     : 1.0 - initial release
// ============================================================================
module tb_digiota_trim_cal;

  localparam int TW = 6;
  localparam int SC = 16;
  localparam int NV = 3;
  localparam int P  = SC + NV + 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cmp_in;
  logic          flip;
  logic [TW-1:0] trim;
  logic [TW-1:0] cal_code;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int tgt      = 0;
  int mode     = 0;
  int ph       = 0;
  int bcnt     = 0;
  int mon_exp  = 0;
  bit rec_en   = 1'b0;
  int sb[$];
  int exp_trials[$];
  int trim_log[$];

  always #5 clk = ~clk;

  digiota_trim_cal #(
    .TRIM_W        (TW),
    .SETTLE_CYCLES (SC),
    .VOTES         (NV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .cmp_in   (cmp_in),
    .trim     (trim),
    .cal_code (cal_code),
    .busy     (busy),
    .done     (done)
  );

  // Position of the current cycle within a calibration, counted from the first busy cycle
  always @(posedge clk) ph <= busy ? ph + 1 : 0;

  // OTA comparator model with optional corruption of chosen vote samples
  always_comb begin
    flip = 1'b0;
    if (busy && mode == 1 && (ph % P) == SC - 1) flip = 1'b1;
    if (busy && mode == 2 && ph < P && ((ph % P) == SC - 1 || (ph % P) == SC)) flip = 1'b1;
    cmp_in = ((int'(trim) <= tgt) ? 1'b1 : 1'b0) ^ flip;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: binary search where each bit sees NV votes, 'wrong' of them inverted
  task automatic model(input int target, input int m, output int code);
    int trial, wrong, ones;
    bit good;
    code = 0;
    exp_trials.delete();
    for (int b = TW - 1; b >= 0; b--) begin
      trial = code | (1 << b);
      exp_trials.push_back(trial);
      good  = (trial <= target);
      wrong = (m == 1) ? 1 : ((m == 2 && b == TW - 1) ? 2 : 0);
      ones  = good ? NV - wrong : wrong;
      if (ones > NV / 2) code = trial;
    end
  endtask

  always @(negedge clk) begin
    if (rec_en && busy && (ph % P) == 1) trim_log.push_back(int'(trim));
    if (done) begin
      check("done_expected", int'(sb.size() > 0), 1);
      check("busy_in_done", int'(busy), 0);
      check("run_length", bcnt, TW * P);
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        check("cal_code", int'(cal_code), mon_exp);
        check("trim_final", int'(trim), mon_exp);
      end
      bcnt = 0;
    end else if (busy) begin
      bcnt++;
    end else begin
      bcnt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input int t, input int m);
    tgt   = t;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < TW * P * 3 && sb.size() != 0; i++) tick();
    check("drain_timeout", sb.size(), 0);
    sb.delete();
    tick();
  endtask

  task automatic run_expect(input int t, input int m);
    int code;
    model(t, m, code);
    sb.push_back(code);
    kick(t, m);
    drain();
  endtask

  task automatic wait_ph(input int target);
    for (int i = 0; i < 400 && ph != target; i++) tick();
    check("reach_phase", ph, target);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_trim", int'(trim), 32);
    check("rst_cal", int'(cal_code), 32);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);

    run_expect(37, 0);
    check("idle_busy", int'(busy), 0);
    check("idle_trim37", int'(trim), 37);

    run_expect(0, 0);
    trim_log.delete();
    rec_en = 1'b1;
    run_expect(63, 0);
    rec_en = 1'b0;
    model(63, 0, c);
    check("trial_count", trim_log.size(), exp_trials.size());
    for (int i = 0; i < exp_trials.size() && i < trim_log.size(); i++)
      check("trial_seq", trim_log[i], exp_trials[i]);

    run_expect(37, 1);
    run_expect(37, 2);
    check("msb_flip_result", int'(cal_code), 31);

    repeat (4) run_expect(int'($urandom_range(0, 63)), int'($urandom_range(0, 1)));

    run_expect(37, 0);
    kick(10, 0);
    wait_ph(2 * P + 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_trim", int'(trim), 37);
    check("abort_cal", int'(cal_code), 37);
    check("abort_done", int'(done), 0);
    repeat (P) tick();
    check("abort_stays_idle", int'(busy), 0);

    model(45, 0, c);
    sb.push_back(c);
    kick(45, 0);
    wait_ph(30);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain();
    repeat (3) tick();
    check("no_restart", int'(busy), 0);

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", int'(busy), 0);
    tick();
    check("abort_start_idle2", int'(busy), 0);
    check("abort_start_trim", int'(trim), 45);

    model(20, 0, c);
    sb.push_back(c);
    kick(20, 0);
    wait_ph(P - 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_trim", int'(trim), 32);
    check("arst_cal", int'(cal_code), 32);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    run_expect(50, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
